// File: rtl/piso_byte_feeder.sv
// rtl/piso_byte_feeder.sv - feeds a multi-byte word, MSB byte first, into an 8-bit PISO shift register
module piso_byte_feeder #(
    parameter int NBYTES = 4,
    parameter int GAP    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8*NBYTES-1:0]   word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic                  abort,
    output logic [7:0]            pi,
    output logic                  load,
    output logic                  en_L,
    output logic                  cs_n,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_TAIL,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [8*NBYTES-1:0]   shadow, shadow_nxt;
    logic [8*NBYTES-1:0]   shifted;
    logic [IW-1:0]         idx, idx_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic [GW-1:0]         gap_cnt, gap_nxt;
    logic [7:0]            pi_nxt;

    // Next-state, counter and shadow update; outputs are decoded from the next state
    // so every output comes straight from a flop.
    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        gap_nxt    = gap_cnt;
        case (state)
            S_IDLE: begin
                if (word_valid) begin
                    shadow_nxt = word_in;
                    idx_nxt    = IW'(NBYTES - 1);
                    cnt_nxt    = '0;
                    state_nxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_nxt   = '0;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    // Index reaching zero is terminal: the last byte always ends in TAIL.
                    if (idx == '0) begin
                        state_nxt = S_TAIL;
                    end else begin
                        idx_nxt = idx - IW'(1);
                        if (GAP > 0) begin
                            gap_nxt   = '0;
                            state_nxt = S_GAP;
                        end else begin
                            state_nxt = S_LOAD;
                        end
                    end
                end
            end
            S_GAP: begin
                gap_nxt = gap_cnt + GW'(1);
                if (gap_cnt == GW'(GAP - 1)) begin
                    state_nxt = S_LOAD;
                end
            end
            S_TAIL:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Cancel wins over everything except a fresh handshake in IDLE.
        if (abort && (state != S_IDLE)) begin
            state_nxt  = S_IDLE;
            shadow_nxt = '0;
            idx_nxt    = '0;
            cnt_nxt    = '0;
            gap_nxt    = '0;
        end

        shifted = shadow_nxt >> (8 * idx_nxt);
        pi_nxt  = (state_nxt == S_LOAD) ? shifted[7:0] : pi;
    end

    // State, counters, shadow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shadow     <= '0;
            idx        <= '0;
            cnt        <= '0;
            gap_cnt    <= '0;
            pi         <= '0;
            word_ready <= 1'b1;
            load       <= 1'b0;
            en_L       <= 1'b1;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            shadow     <= shadow_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            gap_cnt    <= gap_nxt;
            pi         <= pi_nxt;
            word_ready <= (state_nxt == S_IDLE);
            busy       <= (state_nxt != S_IDLE);
            load       <= (state_nxt == S_LOAD);
            en_L       <= !((state_nxt == S_LOAD) || (state_nxt == S_SHIFT));
            cs_n       <= (state_nxt == S_IDLE) || (state_nxt == S_DONE);
            done       <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_piso_byte_feeder.sv
// tb/tb_piso_byte_feeder.sv - self-checking bench for piso_byte_feeder
module tb_piso_byte_feeder;

    logic        clk;
    logic        rst_n;
    int          cyc;
    int          errors;
    int          checks;

    // main instance: NBYTES=4, GAP=0
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        abort;
    logic [7:0]  pi;
    logic        load;
    logic        en_l;
    logic        cs_n;
    logic        busy;
    logic        done;

    // gap instance: NBYTES=2, GAP=3
    logic [15:0] g_word_in;
    logic        g_valid;
    logic        g_ready;
    logic        g_abort;
    logic [7:0]  g_pi;
    logic        g_load;
    logic        g_en_l;
    logic        g_cs_n;
    logic        g_busy;
    logic        g_done;

    piso_byte_feeder #(.NBYTES(4), .GAP(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .abort(abort), .pi(pi), .load(load),
        .en_L(en_l), .cs_n(cs_n), .busy(busy), .done(done)
    );

    piso_byte_feeder #(.NBYTES(2), .GAP(3)) u_gap (
        .clk(clk), .rst_n(rst_n), .word_in(g_word_in), .word_valid(g_valid),
        .word_ready(g_ready), .abort(g_abort), .pi(g_pi), .load(g_load),
        .en_L(g_en_l), .cs_n(g_cs_n), .busy(g_busy), .done(g_done)
    );

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ev_t;

    ev_t  exp_load[$];
    int   exp_done[$];
    logic exp_bits[$];
    ev_t  m_e;
    int   m_d;
    logic m_b;
    logic [7:0] sr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // external shift register model attached to the main instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sr <= 8'h00;
        else if (load)   sr <= pi;
        else if (!en_l)  sr <= {sr[6:0], 1'b0};
    end

    // scoreboard monitor for the main instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (load) begin
                checks++;
                if (exp_load.size() == 0) begin
                    errors++;
                    $display("FAIL load_unexpected cyc=%0d pi=%h", cyc, pi);
                end else begin
                    m_e = exp_load.pop_front();
                    if (cyc !== m_e.cyc || pi !== m_e.val) begin
                        errors++;
                        $display("FAIL load_event got cyc=%0d pi=%h want cyc=%0d pi=%h", cyc, pi, m_e.cyc, m_e.val);
                    end
                end
                checks++;
                if (en_l !== 1'b0) begin
                    errors++;
                    $display("FAIL load_with_en_off got en_L=%b want 0", en_l);
                end
            end
            if (done) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d", cyc);
                end else begin
                    m_d = exp_done.pop_front();
                    if (cyc !== m_d || cs_n !== 1'b1 || word_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL done_event got cyc=%0d cs_n=%b rdy=%b want cyc=%0d cs_n=1 rdy=0", cyc, cs_n, word_ready, m_d);
                    end
                end
            end
            if (!en_l && !load) begin
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL serial_unexpected cyc=%0d", cyc);
                end else begin
                    m_b = exp_bits.pop_front();
                    if (sr[7] !== m_b) begin
                        errors++;
                        $display("FAIL serial_bit cyc=%0d got %b want %b", cyc, sr[7], m_b);
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input int t);
        ev_t e;
        for (int k = 0; k < 4; k++) begin
            e.cyc = t + 1 + 9 * k;
            e.val = w[8*(3-k) +: 8];
            exp_load.push_back(e);
            for (int b = 7; b >= 0; b--) exp_bits.push_back(e.val[b]);
        end
        exp_done.push_back(t + 38);
    endtask

    task automatic flush_expect();
        exp_load.delete();
        exp_done.delete();
        exp_bits.delete();
    endtask

    // called at a negedge; returns at the negedge after the accept edge
    task automatic send_word(input logic [31:0] w, input bit hold, output int t);
        int n;
        n = 0;
        while (word_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (word_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready_timeout got rdy=%b want 1", word_ready);
        end
        word_in    = w;
        word_valid = 1'b1;
        t          = cyc;
        push_word(w, t);
        @(negedge clk);
        if (!hold) word_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_load.size() + exp_done.size() + exp_bits.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((exp_load.size() + exp_done.size() + exp_bits.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d want 0",
                     exp_load.size() + exp_done.size() + exp_bits.size());
        end
        @(negedge clk);
        checks++;
        if (word_ready !== 1'b1 || busy !== 1'b0 || cs_n !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_word got rdy=%b busy=%b cs_n=%b want 1 0 1", word_ready, busy, cs_n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({word_ready, cs_n, en_l, load, done, busy, pi} !== {6'b111000, 8'h00}) begin
            errors++;
            $display("FAIL reset_main got rdy=%b cs_n=%b en_L=%b load=%b done=%b busy=%b pi=%h want 1 1 1 0 0 0 00",
                     word_ready, cs_n, en_l, load, done, busy, pi);
        end
        checks++;
        if ({g_ready, g_cs_n, g_en_l, g_load, g_done, g_busy, g_pi} !== {6'b111000, 8'h00}) begin
            errors++;
            $display("FAIL reset_gap got rdy=%b cs_n=%b en_L=%b load=%b done=%b pi=%h want 1 1 1 0 0 00",
                     g_ready, g_cs_n, g_en_l, g_load, g_done, g_pi);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int t;
        int en_cnt;
        logic exp_cs;
        logic exp_rdy;
        en_cnt = 0;
        send_word(32'hA5C30F81, 1'b0, t);
        for (int c = 1; c <= 39; c++) begin
            if (c > 1) @(negedge clk);
            exp_cs  = !(c <= 37);
            exp_rdy = (c == 39);
            if (!en_l) en_cnt++;
            checks++;
            if (cs_n !== exp_cs || word_ready !== exp_rdy) begin
                errors++;
                $display("FAIL basic_frame T+%0d got cs_n=%b rdy=%b want %b %b", c, cs_n, word_ready, exp_cs, exp_rdy);
            end
        end
        checks++;
        if (en_cnt != 36) begin
            errors++;
            $display("FAIL basic_en_count got %0d want 36", en_cnt);
        end
        wait_drain();
    endtask

    task automatic test_gap();
        int t;
        logic [3:0] got;
        logic [3:0] want;
        int n;
        n = 0;
        while (g_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        g_word_in = 16'h3CF0;
        g_valid   = 1'b1;
        t         = cyc;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            g_valid = 1'b0;
            got  = {g_load, g_en_l, g_cs_n, g_done};
            want = {(c == 1 || c == 13),
                    !((c >= 1 && c <= 9) || (c >= 13 && c <= 21)),
                    !(c >= 1 && c <= 22),
                    (c == 23)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL gap_cycle T+%0d got load,en_L,cs_n,done=%b want %b", c, got, want);
            end
            if (c == 1 || c == 13) begin
                checks++;
                if (g_pi !== ((c == 1) ? 8'h3C : 8'hF0)) begin
                    errors++;
                    $display("FAIL gap_pi T+%0d got %h want %h", c, g_pi, (c == 1) ? 8'h3C : 8'hF0);
                end
            end
        end
    endtask

    task automatic test_abort();
        int t;
        send_word(32'hFFFFFFFF, 1'b0, t);
        wait_cyc(t + 14);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({word_ready, busy, cs_n, en_l, load, done} !== 6'b101100) begin
            errors++;
            $display("FAIL abort_idle got rdy=%b busy=%b cs_n=%b en_L=%b load=%b done=%b want 1 0 1 1 0 0",
                     word_ready, busy, cs_n, en_l, load, done);
        end
        checks++;
        if (exp_load.size() != 2 || exp_bits.size() != 20) begin
            errors++;
            $display("FAIL abort_progress got loads_left=%0d bits_left=%0d want 2 20", exp_load.size(), exp_bits.size());
        end
        flush_expect();
        repeat (5) @(negedge clk);
        send_word(32'h00000001, 1'b0, t);
        wait_drain();
        checks++;
        if (pi !== 8'h01) begin
            errors++;
            $display("FAIL abort_last_pi got %h want 01", pi);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        send_word(32'h1234ABCD, 1'b1, t1);
        push_word(32'h5AA5F00F, t1 + 39);
        word_in = 32'hDEADBEEF;
        wait_cyc(t1 + 30);
        word_in = 32'h5AA5F00F;
        wait_cyc(t1 + 39);
        checks++;
        if (word_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready got %b want 1", word_ready);
        end
        @(negedge clk);
        word_valid = 1'b0;
        word_in    = 32'h0BADF00D;
        checks++;
        if (load !== 1'b1 || pi !== 8'h5A) begin
            errors++;
            $display("FAIL b2b_second_load got load=%b pi=%h want 1 5a", load, pi);
        end
        wait_drain();
        repeat (3) @(negedge clk);
        checks++;
        if (word_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_extra got rdy=%b busy=%b want 1 0", word_ready, busy);
        end
    endtask

    task automatic test_async_reset();
        int t;
        send_word(32'h12345678, 1'b0, t);
        wait_cyc(t + 5);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({word_ready, cs_n, en_l, load, done, busy, pi} !== {6'b111000, 8'h00}) begin
            errors++;
            $display("FAIL async_reset got rdy=%b cs_n=%b en_L=%b load=%b done=%b busy=%b pi=%h want 1 1 1 0 0 0 00",
                     word_ready, cs_n, en_l, load, done, busy, pi);
        end
        flush_expect();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(32'hDEADBEEF, 1'b0, t);
        wait_drain();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        cyc        = 0;
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        abort      = 1'b0;
        g_word_in  = '0;
        g_valid    = 1'b0;
        g_abort    = 1'b0;
        test_reset();
        test_basic();
        test_gap();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
